// File: rtl/data_ram_arbiter.sv
// data_ram_arbiter: two-port arbiter in front of a single-ported data RAM.
//
// Port 0 is the CPU memory stage; port 1 is the loader/debug port. Each grant
// cycle is one complete transfer. The RAM is driven combinationally from the
// granted port. Read data is registered, so reads have 1-cycle latency.
// When both ports request, the current owner keeps the RAM for up to MAX_BURST
// consecutive grants. After that, ownership passes to the other port.
//
// Ports:
//   i_Clk, i_Rst              clock, synchronous active-high reset
//   i_reqN, i_weN             transfer request, 1 = write / 0 = read
//   i_addrN, i_wdataN         byte address and write data
//   o_gntN                    transfer accepted this cycle
//   o_rdataN, o_rvalidN       registered read data and its valid pulse
//   o_errN                    misaligned-access pulse (cycle after the grant)
//   o_ram_ce/we/addr/wdata    RAM control, address and write data
//   i_ram_rdata               combinational RAM read data
//   o_busy                    arbiter is not idle
module data_ram_arbiter #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic        i_Clk,
    input  logic        i_Rst,
    input  logic        i_req0,
    input  logic        i_req1,
    input  logic        i_we0,
    input  logic        i_we1,
    input  logic [31:0] i_addr0,
    input  logic [31:0] i_addr1,
    input  logic [31:0] i_wdata0,
    input  logic [31:0] i_wdata1,
    output logic        o_gnt0,
    output logic        o_gnt1,
    output logic [31:0] o_rdata0,
    output logic [31:0] o_rdata1,
    output logic        o_rvalid0,
    output logic        o_rvalid1,
    output logic        o_err0,
    output logic        o_err1,
    output logic        o_ram_ce,
    output logic        o_ram_we,
    output logic [31:0] o_ram_addr,
    output logic [31:0] o_ram_wdata,
    input  logic [31:0] i_ram_rdata,
    output logic        o_busy
);

    localparam int unsigned CntW = $clog2(MAX_BURST + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_BURST);

    typedef enum logic [1:0] {StIdle, StOwn0, StOwn1} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [31:0]     rdata0_q, rdata1_q;
    logic            rvalid0_q, rvalid1_q;
    logic            err0_q, err1_q;

    logic gnt0, gnt1;
    logic aligned0, aligned1;
    logic sel_we, sel_aligned;
    logic [31:0] sel_addr, sel_wdata;

    assign aligned0 = (i_addr0[1:0] == 2'b00);
    assign aligned1 = (i_addr1[1:0] == 2'b00);

    // Grant decision. Reset masks all grants, whatever the requests.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!i_Rst) begin
            if (i_req0 && i_req1) begin
                case (state_q)
                    StOwn0: begin
                        if (cnt_q < CntMax) gnt0 = 1'b1;
                        else                gnt1 = 1'b1;
                    end
                    StOwn1: begin
                        if (cnt_q < CntMax) gnt1 = 1'b1;
                        else                gnt0 = 1'b1;
                    end
                    default: gnt0 = 1'b1;
                endcase
            end else begin
                gnt0 = i_req0;
                gnt1 = i_req1;
            end
        end
    end

    assign o_gnt0 = gnt0;
    assign o_gnt1 = gnt1;

    // RAM drive from the granted port. A misaligned access keeps its grant
    // but never enables the RAM, so a misaligned write cannot corrupt memory.
    assign sel_we      = gnt1 ? i_we1    : i_we0;
    assign sel_addr    = gnt1 ? i_addr1  : i_addr0;
    assign sel_wdata   = gnt1 ? i_wdata1 : i_wdata0;
    assign sel_aligned = gnt1 ? aligned1 : aligned0;

    always_comb begin
        o_ram_ce    = 1'b0;
        o_ram_we    = 1'b0;
        o_ram_addr  = 32'h0;
        o_ram_wdata = 32'h0;
        if (gnt0 || gnt1) begin
            o_ram_ce    = sel_aligned;
            o_ram_we    = sel_we & sel_aligned;
            o_ram_addr  = sel_addr;
            o_ram_wdata = sel_wdata;
        end
    end

    // Ownership and burst-count update.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (gnt0) begin
            if (state_q == StOwn0) begin
                cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
            end else begin
                state_d = StOwn0;
                cnt_d   = CntW'(1);
            end
        end else if (gnt1) begin
            if (state_q == StOwn1) begin
                cnt_d = (cnt_q == CntMax) ? cnt_q : cnt_q + CntW'(1);
            end else begin
                state_d = StOwn1;
                cnt_d   = CntW'(1);
            end
        end else begin
            state_d = StIdle;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            rdata0_q  <= 32'h0;
            rdata1_q  <= 32'h0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rvalid0_q <= gnt0 && aligned0 && !i_we0;
            rvalid1_q <= gnt1 && aligned1 && !i_we1;
            err0_q    <= gnt0 && !aligned0;
            err1_q    <= gnt1 && !aligned1;
            if (gnt0 && aligned0 && !i_we0) rdata0_q <= i_ram_rdata;
            if (gnt1 && aligned1 && !i_we1) rdata1_q <= i_ram_rdata;
        end
    end

    // A pulse registered just before reset is asserted is dropped
    // while reset is held.
    assign o_rvalid0 = rvalid0_q & ~i_Rst;
    assign o_rvalid1 = rvalid1_q & ~i_Rst;
    assign o_err0    = err0_q & ~i_Rst;
    assign o_err1    = err1_q & ~i_Rst;
    assign o_rdata0  = rdata0_q;
    assign o_rdata1  = rdata1_q;
    assign o_busy    = (state_q != StIdle);

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed self-checking bench for data_ram_arbiter with a 64-word RAM model.
module tb_data_ram_arbiter;

    logic        clk;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1;
    logic [31:0] rdata0, rdata1;
    logic        rvalid0, rvalid1, err0, err1;
    logic        ram_ce, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;
    logic        busy;

    int vectors = 0;
    int miscompares = 0;

    logic [31:0] mem [0:63];

    data_ram_arbiter #(.MAX_BURST(4)) dut (
        .i_Clk       (clk),
        .i_Rst       (rst),
        .i_req0      (req0),
        .i_req1      (req1),
        .i_we0       (we0),
        .i_we1       (we1),
        .i_addr0     (addr0),
        .i_addr1     (addr1),
        .i_wdata0    (wdata0),
        .i_wdata1    (wdata1),
        .o_gnt0      (gnt0),
        .o_gnt1      (gnt1),
        .o_rdata0    (rdata0),
        .o_rdata1    (rdata1),
        .o_rvalid0   (rvalid0),
        .o_rvalid1   (rvalid1),
        .o_err0      (err0),
        .o_err1      (err1),
        .o_ram_ce    (ram_ce),
        .o_ram_we    (ram_we),
        .o_ram_addr  (ram_addr),
        .o_ram_wdata (ram_wdata),
        .i_ram_rdata (ram_rdata),
        .o_busy      (busy)
    );

    always #5 clk = ~clk;

    // RAM model: loaded with a known pattern while reset is held.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 64; i++) mem[i] <= 32'hA000_0000 + 32'(i);
            mem[4] <= 32'hDEAD_BEEF;
        end else if (ram_ce && ram_we) begin
            mem[ram_addr[7:2]] <= ram_wdata;
        end
    end

    assign ram_rdata = mem[ram_addr[7:2]];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic drive(input logic r0, input logic w0, input logic [31:0] a0,
                         input logic [31:0] d0, input logic r1, input logic w1,
                         input logic [31:0] a1, input logic [31:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
    endtask

    int tie_exp0 [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};

    initial begin
        clk = 1'b0;
        rst = 1'b1;
        drive(1, 0, 32'h10, 0, 0, 0, 0, 0);

        // Reset: grants masked even with a request present.
        cyc(); cyc(); settle();
        chk("rst_gnt0", 32'(gnt0), 0);
        chk("rst_ce", 32'(ram_ce), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_rvalid0", 32'(rvalid0), 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_err0", 32'(err0), 0);

        // Single read of word 4.
        cyc(); rst = 1'b0; drive(1, 0, 32'h10, 0, 0, 0, 0, 0); settle();
        chk("rd_gnt0", 32'(gnt0), 1);
        chk("rd_gnt1", 32'(gnt1), 0);
        chk("rd_ce", 32'(ram_ce), 1);
        chk("rd_we", 32'(ram_we), 0);
        chk("rd_addr", ram_addr, 32'h10);
        chk("rd_busy_idle", 32'(busy), 0);
        cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0); settle();
        chk("rd_rvalid0", 32'(rvalid0), 1);
        chk("rd_rdata0", rdata0, 32'hDEAD_BEEF);
        chk("idle_ce", 32'(ram_ce), 0);
        chk("idle_addr", ram_addr, 0);
        chk("rd_busy", 32'(busy), 1);
        cyc(); settle();
        chk("rd_rvalid0_drop", 32'(rvalid0), 0);
        chk("rd_busy_drop", 32'(busy), 0);
        chk("rd_rdata0_hold", rdata0, 32'hDEAD_BEEF);

        // Port 1 write, then port 0 read of the same word.
        cyc(); drive(0, 0, 0, 0, 1, 1, 32'h20, 32'h1234_5678); settle();
        chk("wr_gnt1", 32'(gnt1), 1);
        chk("wr_ram_we", 32'(ram_we), 1);
        chk("wr_ram_addr", ram_addr, 32'h20);
        chk("wr_ram_wdata", ram_wdata, 32'h1234_5678);
        cyc(); drive(1, 0, 32'h20, 0, 0, 0, 0, 0); settle();
        chk("wr_rd_gnt0", 32'(gnt0), 1);
        chk("wr_no_rvalid1", 32'(rvalid1), 0);
        cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0); settle();
        chk("wr_rd_rvalid0", 32'(rvalid0), 1);
        chk("wr_rd_rdata0", rdata0, 32'h1234_5678);

        // Read on port 0 followed by a write on port 1 to the same word.
        cyc(); drive(1, 0, 32'h30, 0, 0, 0, 0, 0); settle();
        chk("rw_gnt0", 32'(gnt0), 1);
        cyc(); drive(0, 0, 0, 0, 1, 1, 32'h30, 32'hCAFE_F00D); settle();
        chk("rw_gnt1", 32'(gnt1), 1);
        chk("rw_rvalid0", 32'(rvalid0), 1);
        chk("rw_old_data", rdata0, 32'hA000_000C);
        cyc(); drive(0, 0, 0, 0, 1, 0, 32'h30, 0); settle();
        chk("rw_rd1_gnt1", 32'(gnt1), 1);
        cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0); settle();
        chk("rw_rvalid1", 32'(rvalid1), 1);
        chk("rw_new_data", rdata1, 32'hCAFE_F00D);

        // Tie from idle with MAX_BURST = 4.
        cyc(); drive(1, 0, 32'h0, 0, 1, 0, 32'h4, 0);
        for (int i = 0; i < 9; i++) begin
            settle();
            chk($sformatf("tie_gnt0_%0d", i), 32'(gnt0), 32'(tie_exp0[i]));
            chk($sformatf("tie_gnt1_%0d", i), 32'(gnt1), 32'(1 - tie_exp0[i]));
            cyc();
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0); settle();
        chk("tie_rvalid0", 32'(rvalid0), 1);
        chk("tie_rdata0", rdata0, 32'hA000_0000);
        chk("tie_rdata1", rdata1, 32'hA000_0001);

        // Sole requester on port 1 keeps the RAM past the burst limit.
        cyc(); drive(0, 0, 0, 0, 1, 0, 32'h8, 0);
        for (int i = 0; i < 10; i++) begin
            settle();
            chk($sformatf("sole_gnt1_%0d", i), 32'(gnt1), 1);
            chk($sformatf("sole_gnt0_%0d", i), 32'(gnt0), 0);
            cyc();
        end
        // Burst count is saturated, so a competing port 0 wins at once.
        drive(1, 0, 32'h0, 0, 1, 0, 32'h8, 0); settle();
        chk("sat_gnt0", 32'(gnt0), 1);
        chk("sat_gnt1", 32'(gnt1), 0);
        cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0); settle();
        cyc();

        // Misaligned write on port 0, then misaligned read on port 1.
        drive(1, 1, 32'h13, 32'h5555_5555, 0, 0, 0, 0); settle();
        chk("mis_gnt0", 32'(gnt0), 1);
        chk("mis_ce", 32'(ram_ce), 0);
        cyc(); drive(0, 0, 0, 0, 1, 0, 32'h22, 0); settle();
        chk("mis_err0", 32'(err0), 1);
        chk("mis_rvalid0", 32'(rvalid0), 0);
        chk("mis_rdata0", rdata0, 32'hA000_0000);
        chk("mis_mem4", mem[4], 32'hDEAD_BEEF);
        chk("mis_gnt1", 32'(gnt1), 1);
        chk("mis_ce1", 32'(ram_ce), 0);
        cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0); settle();
        chk("mis_err1", 32'(err1), 1);
        chk("mis_rvalid1", 32'(rvalid1), 0);
        chk("mis_rdata1", rdata1, 32'hA000_0002);
        chk("mis_err0_drop", 32'(err0), 0);

        // Reset in the cycle after a read grant.
        cyc(); drive(1, 0, 32'h10, 0, 0, 0, 0, 0); settle();
        chk("mr_gnt0", 32'(gnt0), 1);
        cyc(); rst = 1'b1; drive(0, 0, 0, 0, 1, 0, 32'h8, 0); settle();
        chk("mr_rvalid0", 32'(rvalid0), 0);
        chk("mr_gnt1", 32'(gnt1), 0);
        chk("mr_ce", 32'(ram_ce), 0);
        cyc(); rst = 1'b0; drive(1, 0, 32'h4, 0, 1, 0, 32'h8, 0); settle();
        chk("mr_busy", 32'(busy), 0);
        chk("mr_rdata0", rdata0, 0);
        chk("mr_tie_gnt0", 32'(gnt0), 1);
        chk("mr_tie_gnt1", 32'(gnt1), 0);
        cyc(); drive(0, 0, 0, 0, 0, 0, 0, 0); settle();
        chk("mr_rvalid0_post", 32'(rvalid0), 1);
        chk("mr_rdata0_post", rdata0, 32'hA000_0001);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
